// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and operation classification for the
// multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_RSV   = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        CL_UNICO = 2'd0,
        CL_SHIFT = 2'd1,
        CL_MUL   = 2'd2,
        CL_DIV   = 2'd3
    } clase_t;

    // Which datapath an opcode can use; operand-dependent shortcuts
    // (shamt=0, divide by zero) are resolved by the caller.
    function automatic clase_t clase_op(input logic [3:0] op);
        clase_t cl;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: cl = CL_SHIFT;
            OP_MUL, OP_MULHU:       cl = CL_MUL;
            OP_DIVU, OP_REMU:       cl = CL_DIV;
            default:                cl = CL_UNICO;
        endcase
        return cl;
    endfunction

endpackage

// File: rtl/alu_comb_nbits.sv
// Purely combinational single-cycle ALU: logic ops, add/sub with carry and
// signed overflow, and signed/unsigned set-less-than.
module alu_comb_nbits
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   operacion_i,
    output logic [N-1:0] res_o,
    output logic         c_o,
    output logic         overflow_o
);

    logic [N:0] suma;
    logic [N:0] resta;

    // Subtraction as a + ~b + 1 so the carry out reads as "no borrow".
    assign suma  = {1'b0, a_i} + {1'b0, b_i};
    assign resta = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};

    always_comb begin
        res_o      = '0;
        c_o        = 1'b0;
        overflow_o = 1'b0;
        case (operacion_i)
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_NOR: res_o = ~(a_i | b_i);
            OP_ADD: begin
                res_o      = suma[N-1:0];
                c_o        = suma[N];
                overflow_o = (a_i[N-1] == b_i[N-1]) && (suma[N-1] != a_i[N-1]);
            end
            OP_SUB: begin
                res_o      = resta[N-1:0];
                c_o        = resta[N];
                overflow_o = (a_i[N-1] != b_i[N-1]) && (resta[N-1] != a_i[N-1]);
            end
            OP_SLTU: res_o = {{(N-1){1'b0}}, (a_i < b_i)};
            OP_SLT:  res_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle ops go straight to FIN, shifts/multiply/divide
// iterate one bit per RUN cycle in a 2N-bit work register.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [N-1:0]  a_i,
    input  logic [N-1:0]  b_i,
    input  logic [3:0]    operacion_i,
    output logic [N-1:0]  salida_o,
    output logic          c_o,
    output logic          zero_o,
    output logic          overflow_o,
    output logic          busy_o,
    output logic          done_o,
    output estado_t       dbg_estado_o
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    estado_t        estado_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] work_q;
    logic [2*N-1:0] work_d;
    logic [N-1:0]   oper_q;
    logic [3:0]     op_q;
    logic [N-1:0]   salida_q;
    logic           c_q;
    logic           zero_q;
    logic           ovf_q;
    logic           done_q;

    logic [N-1:0]   comb_res;
    logic           comb_c;
    logic           comb_ovf;
    logic [SW-1:0]  shamt;
    clase_t         clase;
    logic           iterativo;
    logic [N-1:0]   res_unico;
    logic [N-1:0]   res_iter;
    logic [N:0]     mul_suma;
    logic [N:0]     rem_desp;
    logic [N:0]     dif;
    logic           q_bit;

    alu_comb_nbits #(.N(N)) u_comb (
        .a_i         (a_i),
        .b_i         (b_i),
        .operacion_i (operacion_i),
        .res_o       (comb_res),
        .c_o         (comb_c),
        .overflow_o  (comb_ovf)
    );

    assign shamt = b_i[SW-1:0];
    assign clase = clase_op(operacion_i);

    always_comb begin
        iterativo = 1'b0;
        case (clase)
            CL_SHIFT: iterativo = (shamt != '0);
            CL_MUL:   iterativo = 1'b1;
            CL_DIV:   iterativo = (b_i != '0);
            default:  iterativo = 1'b0;
        endcase
    end

    // Results for requests that finish in one cycle, including the
    // zero-shift and divide-by-zero shortcuts of the iterative ops.
    always_comb begin
        res_unico = comb_res;
        case (operacion_i)
            OP_DIVU:                        res_unico = '1;
            OP_REMU, OP_SLL, OP_SRL, OP_SRA: res_unico = a_i;
            default:                        res_unico = comb_res;
        endcase
    end

    // One iteration step. Multiply keeps {acc_hi, multiplier}; divide keeps
    // {remainder, dividend/quotient} and shifts a quotient bit in at the bottom.
    always_comb begin
        mul_suma = {1'b0, work_q[2*N-1:N]} + {1'b0, oper_q & {N{work_q[0]}}};
        rem_desp = {work_q[2*N-1:N], work_q[N-1]};
        dif      = rem_desp - {1'b0, oper_q};
        q_bit    = ~dif[N];
        work_d   = work_q;
        case (op_q)
            OP_SLL:           work_d = {{N{1'b0}}, work_q[N-2:0], 1'b0};
            OP_SRL:           work_d = {{N{1'b0}}, 1'b0, work_q[N-1:1]};
            OP_SRA:           work_d = {{N{1'b0}}, work_q[N-1], work_q[N-1:1]};
            OP_MUL, OP_MULHU: work_d = {mul_suma, work_q[N-1:1]};
            OP_DIVU, OP_REMU: work_d = {(q_bit ? dif[N-1:0] : rem_desp[N-1:0]),
                                        work_q[N-2:0], q_bit};
            default:          work_d = work_q;
        endcase
        res_iter = work_d[N-1:0];
        case (op_q)
            OP_MULHU, OP_REMU: res_iter = work_d[2*N-1:N];
            default:           res_iter = work_d[N-1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            oper_q   <= '0;
            op_q     <= '0;
            salida_q <= '0;
            c_q      <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (estado_q)
                IDLE, FIN: begin
                    if (start_i) begin
                        op_q <= operacion_i;
                        if (iterativo) begin
                            estado_q <= RUN;
                            cnt_q    <= (clase == CL_SHIFT) ? CW'(shamt) : CW'(N);
                            work_q   <= (clase == CL_MUL) ? {{N{1'b0}}, b_i}
                                                          : {{N{1'b0}}, a_i};
                            oper_q   <= (clase == CL_MUL) ? a_i : b_i;
                        end else begin
                            estado_q <= FIN;
                            salida_q <= res_unico;
                            c_q      <= comb_c;
                            ovf_q    <= comb_ovf;
                            zero_q   <= (res_unico == '0);
                            done_q   <= 1'b1;
                        end
                    end else begin
                        estado_q <= IDLE;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        estado_q <= FIN;
                        salida_q <= res_iter;
                        c_q      <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= (res_iter == '0);
                        done_q   <= 1'b1;
                    end
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign salida_o     = salida_q;
    assign c_o          = c_q;
    assign zero_o       = zero_q;
    assign overflow_o   = ovf_q;
    assign done_o       = done_q;
    assign busy_o       = (estado_q == RUN);
    assign dbg_estado_o = estado_q;

endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 SHALL have parameter: N, 32, operand/result width; power of two, N >= 4.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start_i  input  1  request; sampled only when the unit is idle.
REQ-005 SHALL have port: a_i  input  N  operand A.
REQ-006 SHALL have port: b_i  input  N  operand B; bits [log2(N)-1:0] are the shift amount for shifts.
REQ-007 SHALL have port: operacion_i  input  4  opcode.
REQ-008 SHALL have port: salida_o  output  N  registered result.
REQ-009 SHALL have port: c_o  output  1  registered carry-out.
REQ-010 SHALL have port: zero_o  output  1  registered (salida_o == 0).
REQ-011 SHALL have port: overflow_o  output  1  registered signed overflow.
REQ-012 SHALL have port: busy_o  output  1  iterative operation in progress.
REQ-013 SHALL have port: done_o  output  1  one-cycle pulse; result valid.

Function
REQ-014 SHALL decode opcodes as follows:
- 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0101 SLTU; 0110 SUB; 0111 SLT.
- 1000 SLL; 1001 SRL; 1010 SRA.
- 1100 MUL (low N bits); 1101 MULHU (high N bits, unsigned).
- 1110 DIVU; 1111 REMU.
- 1011 reserved, result 0.
REQ-015 SHALL accept a request on an edge where start_i=1 and state is IDLE or FIN; operands and opcode are captured at that edge.
REQ-016 SHALL define latency L as the cycle after acceptance in which done_o=1, with cycle 1 being the cycle immediately after the accepting edge:
- logic/arith/compare/reserved: L=1.
- shifts: L=shamt+1, so shamt=0 gives L=1.
- MUL/MULHU: L=N+1.
- DIVU/REMU: L=N+1.
- DIVU/REMU with b=0: L=1.
REQ-017 SHALL hold busy_o=1 in cycles 1..L-1 and 0 otherwise; done_o SHALL be 1 only in cycle L.
REQ-018 SHALL ignore start_i while busy_o=1; a request in the done_o cycle SHALL be accepted, giving back-to-back operation.
REQ-019 SHALL use FSM states IDLE, RUN and FIN:
- IDLE to FIN on a single-cycle accept.
- IDLE to RUN on an iterative accept.
- RUN to FIN when the iteration counter expires.
- FIN to IDLE when start_i=0.
- FIN re-accepts as IDLE would when start_i=1.
REQ-020 SHALL implement shifts by one bit position per RUN cycle; SRA SHALL replicate a[N-1].
REQ-021 SHALL implement MUL/MULHU as shift-add, one partial product per cycle, with a 2N-bit accumulator.
REQ-022 SHALL implement DIVU/REMU as restoring division, one quotient bit per cycle.
REQ-023 SHALL return quotient all-ones and remainder = a for b=0.
REQ-024 SHALL compute SUB as a + ~b + 1; c_o SHALL equal the carry out of bit N-1, so c_o=1 means no borrow.
REQ-025 SHALL set overflow_o for ADD/SUB on signed overflow; c_o and overflow_o SHALL be 0 for all other opcodes.
REQ-026 SHALL produce a result of 1 or 0 for SLT (signed) and SLTU (unsigned) compares.
REQ-027 SHALL hold salida_o/c_o/zero_o/overflow_o stable from the done_o cycle until the next done_o.

Reset
REQ-028 SHALL, on rst_i=1 at a rising edge, force state to IDLE, clear all outputs and clear the internal counter and accumulator.
REQ-029 SHALL abort any in-flight operation on reset with no done_o pulse.
REQ-030 SHALL ignore start_i while rst_i=1.

Structure
REQ-031 SHALL place the opcode constants and the FSM state typedef in shared package alu_pkg.
REQ-032 SHALL implement the single-cycle operations (logic, add/sub, compares, flags) in sub-module alu_comb_nbits, parameter N, purely combinational.
REQ-033 SHALL keep the FSM, iteration counter (log2(N)+1 bits) and 2N-bit work register in alu_multiciclo.

Verification (N=32)
REQ-034 SHALL cover ADD: a=0x7FFFFFFF, b=1 -> done_o in cycle 1, salida_o=0x80000000, overflow_o=1, c_o=0, zero_o=0.
REQ-035 SHALL cover SUB: a=5, b=5 -> salida_o=0, zero_o=1, c_o=1; then SLT with a=0xFFFFFFFF, b=1 -> salida_o=1.
REQ-036 SHALL cover SRA: a=0x80000000, b=4 -> busy_o high cycles 1-4, done_o in cycle 5, salida_o=0xF8000000; SLL with b=0 -> done_o in cycle 1.
REQ-037 SHALL cover MULHU: a=b=0xFFFFFFFF -> done_o in cycle 33, salida_o=0xFFFFFFFE; start_i pulses during busy_o are ignored.
REQ-038 SHALL cover DIVU: a=100, b=7 -> salida_o=14 in cycle 33; REMU with the same operands -> 2; DIVU with b=0 -> 0xFFFFFFFF in cycle 1.
REQ-039 SHALL cover reset at cycle 10 of a MUL -> no done_o, all outputs 0, and the next ADD is accepted normally.
